// File: rtl/rgb_seq_pkg.sv
// Shared types, hue-wheel key table and helpers for the RGB fade sequencer.
package rgb_seq_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int NUM_KEYS = 6;

    localparam rgb_t KEY_TABLE [NUM_KEYS] = '{
        '{8'd255, 8'd0,   8'd0  },
        '{8'd255, 8'd255, 8'd0  },
        '{8'd0,   8'd255, 8'd0  },
        '{8'd0,   8'd255, 8'd255},
        '{8'd0,   8'd0,   8'd255},
        '{8'd255, 8'd0,   8'd255}
    };

    typedef enum logic [1:0] {IDLE, HOLD, FADE} seq_state_t;

    // Out-of-range indices fall back to red so the lookup never yields X.
    function automatic rgb_t key_color(input logic [2:0] idx);
        case (idx)
            3'd0:    key_color = KEY_TABLE[0];
            3'd1:    key_color = KEY_TABLE[1];
            3'd2:    key_color = KEY_TABLE[2];
            3'd3:    key_color = KEY_TABLE[3];
            3'd4:    key_color = KEY_TABLE[4];
            3'd5:    key_color = KEY_TABLE[5];
            default: key_color = KEY_TABLE[0];
        endcase
    endfunction

    function automatic logic [2:0] wheel_next(input logic [2:0] idx);
        wheel_next = (idx == 3'(NUM_KEYS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rgb_lerp.sv
// Combinational per-channel interpolation between two keys, with optional
// gamma shaping when RGB_SEQ_GAMMA_EN is defined.
module rgb_lerp
    import rgb_seq_pkg::*;
#(
    parameter int L = 6
) (
    input  rgb_t         a,
    input  rgb_t         b,
    input  logic [L-1:0] k,
    output rgb_t         y
);

    localparam int W = 8 + L + 1;

    function automatic logic [7:0] mix(input logic [7:0] ca, input logic [7:0] cb,
                                       input logic [L-1:0] kk);
        logic [W-1:0] prod;
        prod = W'(ca) * (W'(1 << L) - W'(kk)) + W'(cb) * W'(kk);
        mix  = 8'(prod >> L);
    endfunction

    // The +255 bias keeps full scale at 255 while zero stays at zero.
    function automatic logic [7:0] shape(input logic [7:0] c);
`ifdef RGB_SEQ_GAMMA_EN
        logic [15:0] sq;
        sq    = 16'(c) * 16'(c) + 16'd255;
        shape = 8'(sq >> 8);
`else
        shape = c;
`endif
    endfunction

    assign y.r = shape(mix(a.r, b.r, k));
    assign y.g = shape(mix(a.g, b.g, k));
    assign y.b = shape(mix(a.b, b.b, k));

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Hue-wheel fade sequencer feeding the per-channel PWM compare stage.
// Optional gamma shaping is selected with the RGB_SEQ_GAMMA_EN macro.
module rgb_fade_sequencer #(
    parameter int TICK_DIV        = 187500,
    parameter int FADE_STEPS_LOG2 = 6,
    parameter int HOLD_TICKS      = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       next_key,
    input  logic       pwm_wrap,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       duty_upd,
    output logic [2:0] key_idx,
    output logic       busy
);

    import rgb_seq_pkg::*;

    localparam int L  = FADE_STEPS_LOG2;
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [L-1:0]  K_LAST    = {L{1'b1}};

    seq_state_t    state;
    logic [L-1:0]  k;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tick_cnt;
    rgb_t          interp_q;
    rgb_t          lerp_c;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);
    assign busy = (state != IDLE);

    rgb_lerp #(.L(L)) u_lerp (
        .a (key_color(key_idx)),
        .b (key_color(wheel_next(key_idx))),
        .k (k),
        .y (lerp_c)
    );

    // Duty values only move on a PWM wrap so no period mixes old and new colors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_idx  <= '0;
            k        <= '0;
            hold_cnt <= '0;
            tick_cnt <= '0;
            interp_q <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            duty_upd <= 1'b0;
        end else begin
            interp_q <= lerp_c;
            duty_upd <= pwm_wrap;
            if (pwm_wrap) begin
                red   <= (state == IDLE) ? 8'd0 : interp_q.r;
                green <= (state == IDLE) ? 8'd0 : interp_q.g;
                blue  <= (state == IDLE) ? 8'd0 : interp_q.b;
            end

            if (!enable) begin
                state    <= IDLE;
                k        <= '0;
                hold_cnt <= '0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= HOLD;
                        tick_cnt <= '0;
                    end
                    HOLD: begin
                        if (next_key || (tick && hold_cnt == HOLD_LAST)) begin
                            state    <= FADE;
                            k        <= '0;
                            hold_cnt <= '0;
                            tick_cnt <= '0;
                        end else if (tick) begin
                            hold_cnt <= hold_cnt + HW'(1);
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    FADE: begin
                        if (next_key || (tick && k == K_LAST)) begin
                            state    <= HOLD;
                            key_idx  <= wheel_next(key_idx);
                            k        <= '0;
                            hold_cnt <= '0;
                            tick_cnt <= '0;
                        end else if (tick) begin
                            k        <= k + L'(1);
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: table of per-edge expectations plus
// hand-written next_key / enable corner sequences. Honours RGB_SEQ_GAMMA_EN.
module tb_rgb_fade_sequencer;

    localparam int TICK_DIV = 4;
    localparam int LOG2     = 2;
    localparam int HOLD     = 2;
    localparam int WRAP_PER = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       next_key;
    logic       pwm_wrap;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       duty_upd;
    logic [2:0] key_idx;
    logic       busy;

    int cyc;
    int checks;
    int errors;

    typedef struct {
        int         at_edge;
        logic       enable;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] key;
        logic       busy;
        logic       duty;
    } vec_t;

    vec_t vecs[$];

    rgb_fade_sequencer #(
        .TICK_DIV        (TICK_DIV),
        .FADE_STEPS_LOG2 (LOG2),
        .HOLD_TICKS      (HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .next_key (next_key),
        .pwm_wrap (pwm_wrap),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .duty_upd (duty_upd),
        .key_idx  (key_idx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Expected duty for an interpolated (non-key) channel value.
    function automatic logic [7:0] gm(input int x);
`ifdef RGB_SEQ_GAMMA_EN
        gm = 8'((x * x + 255) >> 8);
`else
        gm = 8'(x);
`endif
    endfunction

    function automatic void add(input int e, input int r, input int g, input int b,
                                input int key, input logic bz, input logic du);
        vec_t v;
        v.at_edge = e;
        v.enable  = 1'b1;
        v.r       = 8'(r);
        v.g       = 8'(g);
        v.b       = 8'(b);
        v.key     = 3'(key);
        v.busy    = bz;
        v.duty    = du;
        vecs.push_back(v);
    endfunction

    // Edges are numbered from reset release; wraps land on multiples of WRAP_PER.
    task automatic step();
        pwm_wrap = ((cyc + 1) % WRAP_PER == 0);
        @(posedge clk);
        #1;
        cyc++;
        next_key = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic applyStimulus(input logic en, input logic nk, input int target);
        run_to(target - 1);
        enable   = en;
        next_key = nk;
        step();
    endtask

    task automatic checkOutput(input string name, input logic [7:0] er, input logic [7:0] eg,
                               input logic [7:0] eb, input logic [2:0] ek, input logic ebusy,
                               input logic eduty, input logic chk_duty);
        checks++;
        if (red !== er || green !== eg || blue !== eb || key_idx !== ek || busy !== ebusy ||
            (chk_duty && duty_upd !== eduty)) begin
            errors++;
            $display("[TB] FAIL %s @edge %0d: got rgb=(%0d,%0d,%0d) key=%0d busy=%0d upd=%0d, expected rgb=(%0d,%0d,%0d) key=%0d busy=%0d upd=%0d",
                     name, cyc, red, green, blue, key_idx, busy, duty_upd,
                     er, eg, eb, ek, ebusy, eduty);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        enable   = 1'b1;
        next_key = 1'b0;
        pwm_wrap = 1'b1;

        @(posedge clk);
        #1;
        pwm_wrap = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset", 8'd0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1);

        rst_n = 1'b1;
        step();
        checkOutput("release_busy", 8'd0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b1);

        // Start, fade 0->1, a middle segment and the 5->0 wrap-around.
        add(3,   0,        0,        0,        0, 1'b1, 1'b0);
        add(4,   255,      0,        0,        0, 1'b1, 1'b1);
        add(5,   255,      0,        0,        0, 1'b1, 1'b0);
        add(12,  255,      0,        0,        0, 1'b1, 1'b1);
        add(16,  255,      gm(63),   0,        0, 1'b1, 1'b1);
        add(20,  255,      gm(127),  0,        0, 1'b1, 1'b1);
        add(24,  255,      gm(191),  0,        0, 1'b1, 1'b1);
        add(25,  255,      gm(191),  0,        1, 1'b1, 1'b0);
        add(28,  255,      255,      0,        1, 1'b1, 1'b1);
        add(40,  gm(191),  255,      0,        1, 1'b1, 1'b1);
        add(52,  0,        255,      0,        2, 1'b1, 1'b1);
        add(64,  0,        255,      gm(63),   2, 1'b1, 1'b1);
        add(124, 255,      0,        255,      5, 1'b1, 1'b1);
        add(136, 255,      0,        gm(191),  5, 1'b1, 1'b1);
        add(140, 255,      0,        gm(127),  5, 1'b1, 1'b1);
        add(144, 255,      0,        gm(63),   5, 1'b1, 1'b1);
        add(145, 255,      0,        gm(63),   0, 1'b1, 1'b0);
        add(148, 255,      0,        0,        0, 1'b1, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].enable, 1'b0, vecs[i].at_edge);
            checkOutput($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b,
                        vecs[i].key, vecs[i].busy, vecs[i].duty, 1'b1);
        end

        // next_key coinciding with a tick while fading at k=1.
        run_to(160);
        checkOutput("fade_k1", 8'd255, gm(63), 8'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 161);
        checkOutput("skip_fade", 8'd255, gm(63), 8'd0, 3'd1, 1'b1, 1'b0, 1'b1);

        // next_key in HOLD starts the fade at once.
        applyStimulus(1'b1, 1'b1, 163);
        run_to(164);
        checkOutput("skip_new_key", 8'd255, 8'd255, 8'd0, 3'd1, 1'b1, 1'b1, 1'b1);
        run_to(168);
        checkOutput("early_fade_k0", 8'd255, 8'd255, 8'd0, 3'd1, 1'b1, 1'b1, 1'b1);
        run_to(172);
        checkOutput("early_fade_k1", gm(191), 8'd255, 8'd0, 3'd1, 1'b1, 1'b1, 1'b1);

        // Drop enable at k=2, then re-enable at the same key.
        applyStimulus(1'b0, 1'b0, 173);
        checkOutput("disable_busy", gm(191), 8'd255, 8'd0, 3'd1, 1'b0, 1'b0, 1'b1);
        run_to(176);
        checkOutput("disable_blank", 8'd0, 8'd0, 8'd0, 3'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 180);
        checkOutput("reenable_busy", 8'd0, 8'd0, 8'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        run_to(184);
        checkOutput("reenable_key", 8'd255, 8'd255, 8'd0, 3'd1, 1'b1, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
